// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, load-use stall and valid/ready capture.
// Optional macro ALU_SHAMT_EN adds shamt/shift_imm ports so shift ops take B from shamt.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] imm,
   input  logic              alu_src,
   input  logic [3:0]        alu_signal_in,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              reg_write_in,
   input  logic              mem_read_in,
   input  logic              exm_we,
   input  logic [ADDR_W-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_data,
   input  logic              exm_load,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
`ifdef ALU_SHAMT_EN
   input  logic [4:0]        shamt,
   input  logic              shift_imm,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_signal,
   output logic [ADDR_W-1:0] rd_out,
   output logic              reg_write_out,
   output logic              mem_read_out
);

   // Index 0 is the rs path, index 1 the rt path.
   logic [1:0][ADDR_W-1:0] src_addr;
   logic [1:0][DATA_W-1:0] src_data;
   logic [1:0][DATA_W-1:0] fwd_val;
   logic [1:0]             exm_hit;
   logic [1:0]             wb_hit;
   logic [1:0]             load_hit;

   logic              rt_used;
   logic              hazard;
   logic              accept;
   logic [DATA_W-1:0] a_next;
   logic [DATA_W-1:0] b_next;

   logic              valid_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [3:0]        op_reg;
   logic [ADDR_W-1:0] rd_reg;
   logic              reg_write_reg;
   logic              mem_read_reg;

   assign src_addr = {rt_addr, rs_addr};
   assign src_data = {rt_data, rs_data};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         // A pending load in EX/MEM has no data yet, so it can never forward.
         assign exm_hit[gi]  = exm_we & ~exm_load & (exm_rd == src_addr[gi]);
         assign wb_hit[gi]   = wb_we & (wb_rd == src_addr[gi]);
         assign load_hit[gi] = exm_load & exm_we & (exm_rd != '0) & (exm_rd == src_addr[gi]);
         assign fwd_val[gi]  = (src_addr[gi] == '0) ? '0 :
                               exm_hit[gi]          ? exm_data :
                               wb_hit[gi]           ? wb_data :
                                                      src_data[gi];
      end
   endgenerate

`ifdef ALU_SHAMT_EN
   logic              shift_sel;
   logic [DATA_W-1:0] shamt_ext;

   assign shift_sel = shift_imm & ((alu_signal_in == 4'b0100) | (alu_signal_in == 4'b0101));
   assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt};
   assign rt_used   = ~alu_src & ~shift_sel;
   assign b_next    = shift_sel ? shamt_ext : (alu_src ? imm : fwd_val[1]);
`else
   assign rt_used   = ~alu_src;
   assign b_next    = alu_src ? imm : fwd_val[1];
`endif

   assign a_next   = fwd_val[0];
   assign hazard   = load_hit[0] | (rt_used & load_hit[1]);
   assign in_ready = (~valid_reg | out_ready) & ~hazard;
   assign accept   = in_valid & in_ready & ~flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg     <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= 4'b0000;
         rd_reg        <= '0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (accept) begin
         valid_reg     <= 1'b1;
         a_reg         <= a_next;
         b_reg         <= b_next;
         op_reg        <= alu_signal_in;
         rd_reg        <= rd_addr;
         reg_write_reg <= reg_write_in;
         mem_read_reg  <= mem_read_in;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid     = valid_reg;
   assign alu_a         = a_reg;
   assign alu_b         = b_reg;
   assign alu_signal    = op_reg;
   assign rd_out        = rd_reg;
   assign reg_write_out = reg_write_reg & valid_reg;
   assign mem_read_out  = mem_read_reg & valid_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table plus scoreboard, with hand sequences for
// reset, load-use stall, backpressure and flush.
module tb_id_ex_stage;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [31:0] imm;
      logic        src;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        ew;
      logic [4:0]  erd;
      logic [31:0] ed;
      logic        el;
      logic        ww;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        si;
      logic [4:0]  sh;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs_addr, rt_addr, rd_addr, exm_rd, wb_rd;
   logic [31:0] rs_data, rt_data, imm, exm_data, wb_data;
   logic        alu_src, reg_write_in, mem_read_in;
   logic [3:0]  alu_signal_in;
   logic        exm_we, exm_load, wb_we, flush;
   logic [4:0]  shamt;
   logic        shift_imm;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_signal;
   logic [4:0]  rd_out;
   logic        reg_write_out, mem_read_out;

   int   tests = 0;
   int   fails = 0;
   exp_t cur_exp;
   exp_t sb[$];
   vec_t v[9];
   vec_t h;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .imm(imm), .alu_src(alu_src), .alu_signal_in(alu_signal_in), .rd_addr(rd_addr),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
      .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data), .exm_load(exm_load),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
`ifdef ALU_SHAMT_EN
      .shamt(shamt), .shift_imm(shift_imm),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_signal(alu_signal), .rd_out(rd_out), .reg_write_out(reg_write_out),
      .mem_read_out(mem_read_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rs_addr = t.rs;  rt_addr = t.rt;  rs_data = t.rsd; rt_data = t.rtd;
      imm = t.imm;     alu_src = t.src; alu_signal_in = t.op; rd_addr = t.rd;
      reg_write_in = t.rw; mem_read_in = t.mr;
      exm_we = t.ew;   exm_rd = t.erd;  exm_data = t.ed;  exm_load = t.el;
      wb_we = t.ww;    wb_rd = t.wrd;   wb_data = t.wd;
      shift_imm = t.si; shamt = t.sh;
      cur_exp = '{a: t.ea, b: t.eb, op: t.op, rd: t.rd, rw: t.rw, mr: t.mr};
   endtask

   // Scoreboard monitor: pop on consumption, push on accept, all at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("sb_underflow", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("sb_alu_a", alu_a, e.a);
                  chk("sb_alu_b", alu_b, e.b);
                  chk("sb_alu_signal", {28'd0, alu_signal}, {28'd0, e.op});
                  chk("sb_rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                  chk("sb_reg_write", {31'd0, reg_write_out}, {31'd0, e.rw});
                  chk("sb_mem_read", {31'd0, mem_read_out}, {31'd0, e.mr});
                  $display("[TB] consumed a=%h b=%h op=%h rd=%0d", alu_a, alu_b, alu_signal, rd_out);
               end
            end else if (out_valid && flush && sb.size() != 0) begin
               e = sb.pop_front();
               $display("[TB] flushed held a=%h", e.a);
            end
            if (in_valid && in_ready && !flush) sb.push_back(cur_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      v[0] = '{rs:5'd1, rt:5'd2, rsd:32'd5, rtd:32'd7, op:4'b0000, rd:5'd3, rw:1'b1,
               ea:32'd5, eb:32'd7, default:'0};
      v[1] = '{rs:5'd3, rt:5'd5, rsd:32'h1, rtd:32'h2, op:4'd1, rd:5'd4, rw:1'b1,
               ew:1'b1, erd:5'd3, ed:32'hAA, ww:1'b1, wrd:5'd3, wd:32'hBB,
               ea:32'hAA, eb:32'h2, default:'0};
      v[2] = '{rs:5'd3, rt:5'd5, rsd:32'h1, rtd:32'h2, op:4'd1, rd:5'd4, rw:1'b1,
               ew:1'b0, erd:5'd3, ed:32'hAA, ww:1'b1, wrd:5'd3, wd:32'hBB,
               ea:32'hBB, eb:32'h2, default:'0};
      v[3] = '{rs:5'd0, rt:5'd0, rsd:32'h55, rtd:32'h66, op:4'd2, rd:5'd6,
               ew:1'b1, erd:5'd0, ed:32'hAA, ww:1'b1, wrd:5'd0, wd:32'hBB,
               ea:32'h0, eb:32'h0, default:'0};
      v[4] = '{rs:5'd7, rt:5'd6, rsd:32'h11, rtd:32'h9, imm:32'h1234, src:1'b1, op:4'd3,
               rd:5'd8, rw:1'b1, ww:1'b1, wrd:5'd6, wd:32'h77,
               ea:32'h11, eb:32'h1234, default:'0};
      v[5] = '{rs:5'd9, rt:5'd8, rsd:32'h1, rtd:32'h3, op:4'd6, rd:5'd10, rw:1'b1,
               ew:1'b1, erd:5'd8, ed:32'hC0DE, ww:1'b1, wrd:5'd9, wd:32'hBEEF,
               ea:32'hBEEF, eb:32'hC0DE, default:'0};
      v[6] = '{rs:5'd1, rt:5'd4, rsd:32'h21, rtd:32'h5, imm:32'h40, src:1'b1, op:4'd7,
               rd:5'd11, rw:1'b1, ew:1'b1, erd:5'd4, ed:32'h999, el:1'b1,
               ea:32'h21, eb:32'h40, default:'0};
      v[7] = '{rs:5'd11, rt:5'd10, rsd:32'h2, rtd:32'hFFFF, op:4'b0100, rd:5'd12, rw:1'b1,
               si:1'b1, sh:5'd9, ea:32'h2, default:'0};
`ifdef ALU_SHAMT_EN
      v[7].eb = 32'd9;
`else
      v[7].eb = 32'hFFFF;
`endif
      v[8] = '{rs:5'd31, rt:5'd30, rsd:32'hDEADBEEF, rtd:32'h1, op:4'b1010, rd:5'd31,
               rw:1'b1, mr:1'b1, ew:1'b1, erd:5'd30, ed:32'h5, ww:1'b1, wrd:5'd31,
               wd:32'h99, ea:32'h99, eb:32'h5, default:'0};

      // Reset held for two cycles with a valid instruction presented.
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      drive(v[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_signal", {28'd0, alu_signal}, 32'd0);
      chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
      chk("rst_reg_write", {31'd0, reg_write_out}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read_out}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;

      // Back-to-back vectors with out_ready held high: no stall expected.
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         for (int w = 0; w < 10 && !in_ready; w++) @(negedge clk);
      end

      // Load-use stall on rt, then WB forwarding of the loaded value.
      @(posedge clk); #1;
      h = '{rs:5'd1, rt:5'd4, rsd:32'h3, rtd:32'hDEAD, op:4'd2, rd:5'd12, rw:1'b1,
            ew:1'b1, erd:5'd4, el:1'b1, ea:32'h3, eb:32'h10, default:'0};
      drive(h);
      @(negedge clk);
      chk("lu_in_ready_stall", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      h.ew = 1'b0; h.el = 1'b0; h.ww = 1'b1; h.wrd = 5'd4; h.wd = 32'h10;
      drive(h);
      @(negedge clk);
      chk("lu_bubble", {31'd0, out_valid}, 32'd0);
      chk("lu_in_ready_resume", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Backpressure: hold A for three cycles while B waits.
      h = '{rs:5'd2, rt:5'd3, rsd:32'h100, rtd:32'h200, op:4'd1, rd:5'd5, rw:1'b1,
            ea:32'h100, eb:32'h200, default:'0};
      drive(h);
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      h = '{rs:5'd6, rt:5'd7, rsd:32'h300, rtd:32'h1, imm:32'h44, src:1'b1, op:4'd3,
            rd:5'd7, rw:1'b1, mr:1'b1, ea:32'h300, eb:32'h44, default:'0};
      drive(h);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_alu_a_hold", alu_a, 32'h100);
         chk("bp_alu_b_hold", alu_b, 32'h200);
         chk("bp_alu_signal_hold", {28'd0, alu_signal}, 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Flush with a held instruction and a new one incoming.
      h = '{rs:5'd1, rt:5'd2, rsd:32'hC, rtd:32'hD, op:4'd4, rd:5'd9, rw:1'b1,
            ea:32'hC, eb:32'hD, default:'0};
      drive(h);
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      h = '{rs:5'd1, rt:5'd2, rsd:32'hE, rtd:32'hF, op:4'd5, rd:5'd13, rw:1'b1,
            ea:32'hE, eb:32'hF, default:'0};
      drive(h);
      flush = 1'b1;
      @(negedge clk);
      chk("fl_pre_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_reg_write", {31'd0, reg_write_out}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("fl_still_empty", {31'd0, out_valid}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the ALU.
- Captures decoded operands and the 4-bit ALU op under a valid/ready handshake.
- Resolves data forwarding from the EX/MEM and MEM/WB stages at capture time, and stalls on load-use hazards.
- Presents registered alu_a, alu_b and alu_signal plus writeback tags to the ALU and the stages after it.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register-address width; register 0 is hardwired zero.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- rs_addr  input  ADDR_W  source A register index.
- rt_addr  input  ADDR_W  source B register index.
- rs_data  input  DATA_W  register-file value for rs.
- rt_data  input  DATA_W  register-file value for rt.
- imm  input  DATA_W  sign-extended immediate.
- alu_src  input  1  1: B operand = imm; 0: B operand = forwarded rt.
- alu_signal_in  input  4  ALU operation code.
- rd_addr  input  ADDR_W  destination register.
- reg_write_in  input  1  instruction writes rd.
- mem_read_in  input  1  instruction is a load.
- exm_we  input  1  EX/MEM holds a register write.
- exm_rd  input  ADDR_W  EX/MEM destination.
- exm_data  input  DATA_W  EX/MEM result.
- exm_load  input  1  EX/MEM result is a pending load (data not yet available).
- wb_we  input  1  MEM/WB holds a register write.
- wb_rd  input  ADDR_W  MEM/WB destination.
- wb_data  input  DATA_W  MEM/WB result.
- flush  input  1  squash the held and the incoming instruction.
- out_valid  output  1  registered contents are valid.
- out_ready  input  1  downstream consumes the contents this cycle.
- alu_a  output  DATA_W  registered ALU operand A.
- alu_b  output  DATA_W  registered ALU operand B.
- alu_signal  output  4  registered ALU op code.
- rd_out  output  ADDR_W  registered destination.
- reg_write_out  output  1  registered write enable, qualified by out_valid.
- mem_read_out  output  1  registered load flag, qualified by out_valid.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0; alu_a, alu_b, rd_out = 0; alu_signal=4'b0000; reg_write_out=0; mem_read_out=0. Reset mid-transfer discards the held instruction.
- Hazard: hazard = exm_load & exm_we & (exm_rd != 0) & ((exm_rd == rs_addr) | (~alu_src & exm_rd == rt_addr)).
- Handshake: in_ready = (~out_valid | out_ready) & ~hazard. Accept = in_valid & in_ready.
- Forwarding for operand A, priority order:
  - EX/MEM first, when exm_we & ~exm_load & exm_rd == rs_addr & rs_addr != 0;
  - otherwise MEM/WB, when wb_we & wb_rd == rs_addr & rs_addr != 0;
  - otherwise rs_data.
  - rs_addr == 0 always yields 0, regardless of rs_data.
- Forwarding for the forwarded rt value: same rules applied to rt_addr.
- B operand: alu_b <= alu_src ? imm : forwarded rt.
- Clock-edge priority:
  - reset;
  - else flush: out_valid <= 0, input not accepted;
  - else Accept: load all output registers, out_valid <= 1;
  - else if out_ready: out_valid <= 0;
  - else hold all output registers unchanged.
- Latency: one cycle from Accept to out_valid.
- Full throughput: simultaneous out_ready and Accept in the same cycle replaces the held contents with no bubble.
- Stall: while hazard=1, out_valid drops after downstream consumes the held contents (bubble inserted). Next cycle exm_load clears, and the instruction is accepted with wb_data forwarded.
- Output stability: while out_valid=1 & out_ready=0, all outputs stay stable.

Optional Feature:
- Macro ALU_SHAMT_EN.
- Defined:
  - adds input port shamt (5 bits) and input port shift_imm (1 bit);
  - on Accept with shift_imm=1 and alu_signal_in = 4'b0100 or 4'b0101, alu_b <= zero-extended shamt, overriding alu_src;
  - hazard ignores rt_addr in that case.
- Undefined: both ports absent; B operand is selected only by alu_src.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, alu_a=0, alu_b=0, alu_signal=0; first Accept after release, rs_data=5, rt_data=7, alu_signal_in=0000 -> next cycle alu_a=5, alu_b=7, alu_signal=0000.
- Forward priority: rs_addr=3, exm_we=1, exm_rd=3, exm_data=0xAA, wb_we=1, wb_rd=3, wb_data=0xBB -> alu_a=0xAA; with exm_we=0 -> alu_a=0xBB; rs_addr=0 with both matching 0 -> alu_a=0.
- Load-use: exm_load=1, exm_we=1, exm_rd=4, rt_addr=4, alu_src=0 -> in_ready=0 for one cycle and bubble (out_valid=0); next cycle wb_rd=4, wb_data=0x10 -> accepted, alu_b=0x10. With alu_src=1 and only rt_addr matching -> no stall.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid=1 -> in_ready=0 and outputs unchanged; out_ready=1 -> new instruction loaded that same edge.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the incoming instruction is dropped.
- ALU_SHAMT_EN: alu_signal_in=0100, shift_imm=1, shamt=9, rt_data=0xFFFF -> alu_b=9; undefined build -> alu_b=0xFFFF.
